// File: rtl/fsm_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// fsm_crossing_ctrl
//   Pelican-crossing phase sequencer. Drives an external period timer
//   (START / RESET, consumes READY) and builds every phase duration out of
//   whole timer periods ("ticks"). Latches pedestrian requests and decodes
//   the traffic and pedestrian lamps from the current phase.
//
// Parameters
//   G_TICKS   minimum GREEN duration in ticks (>=1)
//   A_TICKS   AMBER duration in ticks (>=1)
//   W_TICKS   RED+WALK duration in ticks (>=1)
//   RA_TICKS  RED+AMBER duration in ticks (>=1)
//
// Ports
//   CLK        in   single clock, rising edge
//   RESET      in   asynchronous, active-high reset
//   REQ        in   pedestrian button, level sampled every cycle
//   TMR_READY  in   timer READY
//   TMR_START  out  timer START (high only while arming the timer)
//   TMR_RESET  out  timer RESET (high only while clearing the timer)
//   GREEN_L    out  traffic green lamp
//   AMBER_L    out  traffic amber lamp
//   RED_L      out  traffic red lamp
//   WALK       out  pedestrian green
//   WAIT       out  request-pending indicator
// ---------------------------------------------------------------------------
module fsm_crossing_ctrl #(
    parameter int G_TICKS  = 2,
    parameter int A_TICKS  = 1,
    parameter int W_TICKS  = 3,
    parameter int RA_TICKS = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic REQ,
    input  logic TMR_READY,
    output logic TMR_START,
    output logic TMR_RESET,
    output logic GREEN_L,
    output logic AMBER_L,
    output logic RED_L,
    output logic WALK,
    output logic WAIT
);

    localparam int MAX_GA = (G_TICKS > A_TICKS) ? G_TICKS : A_TICKS;
    localparam int MAX_WR = (W_TICKS > RA_TICKS) ? W_TICKS : RA_TICKS;
    localparam int MAX_T  = (MAX_GA > MAX_WR) ? MAX_GA : MAX_WR;
    localparam int TW     = $clog2(MAX_T + 1);

    typedef enum logic [1:0] {
        PH_GREEN     = 2'd0,
        PH_AMBER     = 2'd1,
        PH_WALKP     = 2'd2,
        PH_RED_AMBER = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        SUB_ARM   = 2'd0,
        SUB_RUN   = 2'd1,
        SUB_CLEAR = 2'd2,
        SUB_HOLD  = 2'd3
    } sub_t;

    phase_t          phase_q, phase_d;
    sub_t            sub_q, sub_d;
    logic [TW-1:0]   ticks_q, ticks_d, ticks_inc;
    logic            first_q, first_d;
    logic            req_pend_q, req_pend_d;
    logic            req_any;
    logic            enter_walk;

    function automatic logic [TW-1:0] phase_limit(input phase_t p);
        case (p)
            PH_GREEN:  phase_limit = TW'(G_TICKS);
            PH_AMBER:  phase_limit = TW'(A_TICKS);
            PH_WALKP:  phase_limit = TW'(W_TICKS);
            default:   phase_limit = TW'(RA_TICKS);
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_GREEN:  next_phase = PH_AMBER;
            PH_AMBER:  next_phase = PH_WALKP;
            PH_WALKP:  next_phase = PH_RED_AMBER;
            default:   next_phase = PH_GREEN;
        endcase
    endfunction

    // The CLEAR held during reset only zeroes the timer; it is not a tick.
    assign ticks_inc = first_q ? ticks_q : ticks_q + TW'(1);
    assign req_any   = req_pend_q | REQ;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_q    <= PH_GREEN;
            sub_q      <= SUB_CLEAR;
            ticks_q    <= '0;
            first_q    <= 1'b1;
            req_pend_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            sub_q      <= sub_d;
            ticks_q    <= ticks_d;
            first_q    <= first_d;
            req_pend_q <= req_pend_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        sub_d   = sub_q;
        ticks_d = ticks_q;
        first_d = first_q;

        case (sub_q)
            SUB_ARM: sub_d = SUB_RUN;

            SUB_RUN: if (TMR_READY) sub_d = SUB_CLEAR;

            SUB_CLEAR: begin
                first_d = 1'b0;
                if (ticks_inc < phase_limit(phase_q)) begin
                    sub_d   = SUB_ARM;
                    ticks_d = ticks_inc;
                end else if (phase_q == PH_GREEN) begin
                    if (req_any) begin
                        phase_d = PH_AMBER;
                        sub_d   = SUB_ARM;
                        ticks_d = '0;
                    end else begin
                        // Minimum green served; park with the timer idle.
                        sub_d   = SUB_HOLD;
                        ticks_d = ticks_inc;
                    end
                end else begin
                    phase_d = next_phase(phase_q);
                    sub_d   = SUB_ARM;
                    ticks_d = '0;
                end
            end

            SUB_HOLD: begin
                if (req_any) begin
                    phase_d = PH_AMBER;
                    sub_d   = SUB_ARM;
                    ticks_d = '0;
                end
            end

            default: sub_d = SUB_CLEAR;
        endcase
    end

    // A request arriving on the very cycle WALK starts stays pending (set wins).
    assign enter_walk = (phase_d == PH_WALKP) && (phase_q != PH_WALKP);
    assign req_pend_d = (req_pend_q & ~enter_walk) | REQ;

    assign TMR_START = (sub_q == SUB_ARM);
    assign TMR_RESET = (sub_q == SUB_CLEAR);
    assign GREEN_L   = (phase_q == PH_GREEN);
    assign AMBER_L   = (phase_q == PH_AMBER) || (phase_q == PH_RED_AMBER);
    assign RED_L     = (phase_q == PH_WALKP) || (phase_q == PH_RED_AMBER);
    assign WALK      = (phase_q == PH_WALKP);
    assign WAIT      = req_pend_q;

endmodule

// File: tb/tb_fsm_crossing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fsm_crossing_ctrl
//   Directed bench for fsm_crossing_ctrl with a behavioural period timer
//   (N = 4, five-cycle tick) connected downstream. Lamps are viewed as the
//   vector {GREEN_L, AMBER_L, RED_L, WALK}.
// ---------------------------------------------------------------------------
module tb_fsm_crossing_ctrl;

    localparam int TMR_N = 4;

    localparam logic [3:0] L_GREEN = 4'b1000;
    localparam logic [3:0] L_AMBER = 4'b0100;
    localparam logic [3:0] L_WALK  = 4'b0011;
    localparam logic [3:0] L_RA    = 4'b0110;

    logic CLK = 1'b0;
    logic RESET;
    logic REQ;
    logic TMR_READY;
    logic TMR_START;
    logic TMR_RESET;
    logic GREEN_L, AMBER_L, RED_L, WALK, WAIT;

    logic [3:0] lamps;
    int tmr_cnt = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic hold_seen;

    fsm_crossing_ctrl #(
        .G_TICKS (2),
        .A_TICKS (1),
        .W_TICKS (3),
        .RA_TICKS(1)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ      (REQ),
        .TMR_READY(TMR_READY),
        .TMR_START(TMR_START),
        .TMR_RESET(TMR_RESET),
        .GREEN_L  (GREEN_L),
        .AMBER_L  (AMBER_L),
        .RED_L    (RED_L),
        .WALK     (WALK),
        .WAIT     (WAIT)
    );

    always #5 CLK = ~CLK;

    // Period timer: START loads 1, counts up to N, READY on the N-1 count.
    always @(posedge CLK) begin
        if (TMR_RESET)                       tmr_cnt <= 0;
        else if (TMR_START)                  tmr_cnt <= 1;
        else if (tmr_cnt != 0 && tmr_cnt < TMR_N) tmr_cnt <= tmr_cnt + 1;
    end
    assign TMR_READY = (tmr_cnt == TMR_N - 1);

    assign lamps = {GREEN_L, AMBER_L, RED_L, WALK};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Count consecutive cycles (starting with the current one) showing pat.
    task automatic measure(input logic [3:0] pat, output int n);
        n = 0;
        while (lamps == pat && n < 200) begin
            if (GREEN_L && !TMR_START && !TMR_RESET && tmr_cnt == 0)
                hold_seen = 1'b1;
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int g;
        logic ts_seen;
        logic gl_drop;

        RESET     = 1'b1;
        REQ       = 1'b0;
        hold_seen = 1'b0;

        // 1: reset state
        repeat (3) tick();
        check_eq("rst_lamps", 32'(lamps), 32'(L_GREEN));
        check_eq("rst_tmr_reset", 32'(TMR_RESET), 32'd1);
        check_eq("rst_tmr_start", 32'(TMR_START), 32'd0);
        check_eq("rst_wait", 32'(WAIT), 32'd0);
        RESET = 1'b0;
        tick();
        check_eq("arm_after_rst", 32'(TMR_START), 32'd1);
        check_eq("arm_no_reset", 32'(TMR_RESET), 32'd0);

        // 2: no request, minimum green then hold
        repeat (9) tick();
        check_eq("second_clear", 32'(TMR_RESET), 32'd1);
        tick();
        check_eq("hold_start", 32'(TMR_START), 32'd0);
        check_eq("hold_tmr_idle", 32'(tmr_cnt), 32'd0);
        ts_seen = 1'b0;
        gl_drop = 1'b0;
        repeat (89) begin
            tick();
            if (TMR_START) ts_seen = 1'b1;
            if (!GREEN_L)  gl_drop = 1'b1;
        end
        check_eq("hold_no_start", 32'(ts_seen), 32'd0);
        check_eq("hold_green", 32'(gl_drop), 32'd0);

        // 3: request while holding
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        check_eq("hold_wait", 32'(WAIT), 32'd1);
        measure(L_AMBER, n);
        check_eq("t3_amber_len", 32'(n), 32'd5);
        check_eq("t3_walk_wait", 32'(WAIT), 32'd0);
        measure(L_WALK, n);
        check_eq("t3_walk_len", 32'(n), 32'd15);
        measure(L_RA, n);
        check_eq("t3_ra_len", 32'(n), 32'd5);
        check_eq("t3_green", 32'(lamps), 32'(L_GREEN));

        // 4: request in second green cycle
        hold_seen = 1'b0;
        g = 1;
        tick();
        REQ = 1'b1;
        g = 2;
        tick();
        REQ = 1'b0;
        measure(L_GREEN, n);
        check_eq("t4_green_len", 32'(g + n), 32'd10);
        check_eq("t4_no_hold", 32'(hold_seen), 32'd0);
        check_eq("t4_amber", 32'(lamps), 32'(L_AMBER));

        // 5: request on walk-entry cycle and mid walk
        n = 1;
        repeat (4) begin
            tick();
            if (lamps == L_AMBER) n++;
        end
        check_eq("t5_amber_len", 32'(n), 32'd5);
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        check_eq("t5_walk_entry", 32'(lamps), 32'(L_WALK));
        check_eq("t5_set_wins", 32'(WAIT), 32'd1);
        repeat (6) tick();
        REQ = 1'b1;
        tick();
        REQ = 1'b0;
        measure(L_WALK, n);
        check_eq("t5_walk_len", 32'(7 + n), 32'd15);
        check_eq("t5_wait_after", 32'(WAIT), 32'd1);
        measure(L_RA, n);
        check_eq("t5_ra_len", 32'(n), 32'd5);
        hold_seen = 1'b0;
        measure(L_GREEN, n);
        check_eq("t5_green_len", 32'(n), 32'd10);
        check_eq("t5_no_hold", 32'(hold_seen), 32'd0);
        check_eq("t5_amber", 32'(lamps), 32'(L_AMBER));

        // 6: asynchronous reset mid walk
        measure(L_AMBER, n);
        check_eq("t6_amber_len", 32'(n), 32'd5);
        check_eq("t6_walk_wait", 32'(WAIT), 32'd0);
        repeat (6) tick();
        check_eq("t6_in_walk", 32'(lamps), 32'(L_WALK));
        #2 RESET = 1'b1;
        #1;
        check_eq("t6_async_lamps", 32'(lamps), 32'(L_GREEN));
        check_eq("t6_async_treset", 32'(TMR_RESET), 32'd1);
        tick();
        check_eq("t6_tmr_zero", 32'(tmr_cnt), 32'd0);
        RESET = 1'b0;
        tick();
        check_eq("t6_arm", 32'(TMR_START), 32'd1);
        repeat (9) tick();
        check_eq("t6_clear", 32'(TMR_RESET), 32'd1);
        check_eq("t6_green_kept", 32'(GREEN_L), 32'd1);
        tick();
        check_eq("t6_hold", 32'(tmr_cnt == 0 && !TMR_START && GREEN_L), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
